x_scope_dump: RTL and testbench

Autonomous readout engine between the micro-scope capture RAM read port and the UART transmitter. On a start pulse it reads a programmed range of 32-bit scope words and streams each word as 4 bytes, least significant byte first, over a valid/accept byte handshake. It replaces host-driven per-byte address/lane selection, so one command dumps a whole capture.

---
 rtl/x_scope_dump.sv | 111 +++++++++++
 tb/tb_x_scope_dump.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x_scope_dump.sv
// x_scope_dump: reads a range of scope RAM words and streams each as 4 LSB-first bytes to UART TX.
// Define X_SCOPE_DUMP_CSUM_EN to append an XOR checksum byte after the data bytes.
module x_scope_dump #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ren,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_accept
);
    localparam int WC_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
`ifdef X_SCOPE_DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE, CSUM} state_t;
    localparam state_t LAST = CSUM;
`else
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
    localparam state_t LAST = DONE;
`endif
    state_t state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] word;
    logic [1:0]        idx;
    logic [WC_W-1:0]   wcnt;
    logic              start_ok, wait_end, word_end;
    logic [7:0]        cur_byte;

    assign start_ok = state == IDLE && i_start;
    assign wait_end = state == WAIT && wcnt == WC_W'(READ_LAT - 1);
    assign word_end = state == SEND && i_accept && idx == 2'd3;
    assign cur_byte = word[{idx, 3'b000} +: 8];
    assign o_busy   = state != IDLE;
    assign o_done   = state == DONE;
    assign o_ren    = state == READ;
    assign o_raddr  = addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (i_start) state_n = (i_count == '0) ? LAST : READ;
            READ: state_n = WAIT;
            WAIT: if (wait_end) state_n = SEND;
            SEND: if (word_end) state_n = (remaining == (ADDR_W + 1)'(1)) ? LAST : READ;
`ifdef X_SCOPE_DUMP_CSUM_EN
            CSUM: if (i_accept) state_n = DONE;
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
            wcnt      <= '0;
        end else begin
            if (start_ok) begin
                addr      <= i_base;
                remaining <= i_count;
            end
            if (state == READ) wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (wait_end) begin
                word <= i_rdata;
                idx  <= '0;
            end else if (state == SEND && i_accept) begin
                idx <= idx + 1'b1;
            end
            // address wraps naturally at 2^ADDR_W
            if (word_end) begin
                remaining <= remaining - 1'b1;
                addr      <= addr + 1'b1;
            end
        end
    end

`ifdef X_SCOPE_DUMP_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) csum <= '0;
        else if (start_ok) csum <= '0;
        else if (state == SEND && i_accept) csum <= csum ^ cur_byte;
    end

    assign o_valid = state == SEND || state == CSUM;
    assign o_data  = state == SEND ? cur_byte : state == CSUM ? csum : 8'h00;
`else
    assign o_valid = state == SEND;
    assign o_data  = o_valid ? cur_byte : 8'h00;
`endif
endmodule

// File: tb/tb_x_scope_dump.sv
// tb_x_scope_dump: vector table, hand sequences and random dumps checked against a byte-stream model.
// Checksum expectations are enabled with X_SCOPE_DUMP_CSUM_EN.
module tb_x_scope_dump;
    localparam int AW = 11;
    localparam int RL = 1;

    logic          clk = 0, rst = 1, start = 0, accept = 1;
    logic          busy, done, ren, valid;
    logic [AW-1:0] base = '0, raddr;
    logic [AW:0]   count = '0;
    logic [31:0]   rdata = '0;
    logic [7:0]    data;
    logic [31:0]   mem [0:(1<<AW)-1];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] got_b[$], exp_b[$];
    int got_a[$], exp_a[$];
    int busy_n, done_n, inv_bad, stall_n, stall_bad, t_start, t_done, t_fv, t_lx;
    bit done_seen, fv_seen;

    typedef struct {
        logic [AW-1:0] base;
        int            cnt;
        logic [31:0]   w0, w1;
        logic [63:0]   exp;
        int            n;
    } vec_t;
    vec_t tbl[4];

    x_scope_dump #(.ADDR_W(AW), .DATA_W(32), .READ_LAT(RL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_count(count),
        .o_busy(busy), .o_done(done), .o_ren(ren), .o_raddr(raddr), .i_rdata(rdata),
        .o_data(data), .o_valid(valid), .i_accept(accept)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    always @(negedge clk) begin
        if (start && !busy && !rst) t_start = cyc;
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            t_done = cyc;
            done_seen = 1;
        end
        if (ren) got_a.push_back(int'(raddr));
        if (ren && valid) inv_bad++;
        if (valid && !fv_seen) begin
            fv_seen = 1;
            t_fv = cyc;
        end
        if (valid && accept) begin
            got_b.push_back(data);
            t_lx = cyc;
        end
        if (valid && !accept) begin
            stall_n++;
            if (data !== 8'h33) stall_bad++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_b.delete();
        got_a.delete();
        busy_n = 0; done_n = 0; inv_bad = 0; stall_n = 0; stall_bad = 0;
        t_start = -100; t_done = 0; t_fv = 0; t_lx = 0;
        done_seen = 0; fv_seen = 0;
    endtask

    // expected byte stream and read addresses, straight from the dump rules
    task automatic model(input logic [AW-1:0] b, input int c);
        logic [7:0] x;
        logic [31:0] w;
        logic [AW-1:0] a;
        x = '0;
        exp_b.delete();
        exp_a.delete();
        for (int k = 0; k < c; k++) begin
            a = b + AW'(k);
            exp_a.push_back(int'(a));
            w = mem[a];
            for (int j = 0; j < 4; j++) begin
                exp_b.push_back(w[8*j +: 8]);
                x ^= w[8*j +: 8];
            end
        end
`ifdef X_SCOPE_DUMP_CSUM_EN
        exp_b.push_back(x);
`endif
    endtask

    function automatic int exp_time(input int c);
        int t;
        t = (c == 0) ? 1 : (RL + 2) + 4 * c + (RL + 1) * (c - 1);
`ifdef X_SCOPE_DUMP_CSUM_EN
        t++;
`endif
        return t;
    endfunction

    task automatic compare(input int c, input int mode);
        chk("byte_count", got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
            chk($sformatf("byte[%0d]", i), got_b[i], exp_b[i]);
        chk("read_count", got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            chk($sformatf("raddr[%0d]", i), got_a[i], exp_a[i]);
        chk("done_pulses", done_n, 1);
        chk("ren_valid_overlap", inv_bad, 0);
        chk("busy_span", busy_n, t_done - t_start);
        if (exp_b.size() > 0) chk("done_after_last", t_done - t_lx, 1);
        if (mode == 0) begin
            chk("start_to_done", t_done - t_start, exp_time(c));
            if (c > 0) chk("first_valid_latency", t_fv - t_start, RL + 2);
        end
    endtask

    // mode 0: accept high, 1: random accept, 2: 10-cycle stall on byte 2
    task automatic run(input logic [AW-1:0] b, input int c, input int mode, input bit inject);
        int it, stall_left;
        clear_mon();
        stall_left = 10;
        base = b;
        count = (AW + 1)'(c);
        start = 1;
        accept = 1;
        @(posedge clk); #1;
        start = 0;
        it = 0;
        while (!done_seen && it < 8 * c + 100) begin
            case (mode)
                1: accept = $urandom_range(0, 3) != 0;
                2: begin
                    accept = !(got_b.size() == 2 && stall_left > 0);
                    if (!accept) stall_left--;
                end
                default: accept = 1;
            endcase
            start = inject && it == 8;
            @(posedge clk); #1;
            it++;
        end
        start = 0;
        accept = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("done_seen", done_seen, 1);
        model(b, c);
        compare(c, mode);
    endtask

    initial begin
        vec_t t;
        logic [7:0] x;
        int it;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        tbl[0] = '{11'h010, 1, 32'h44332211, 32'h0, 64'h0000_0000_4433_2211, 4};
        tbl[1] = '{11'h7FF, 2, 32'hA0A1A2A3, 32'hB0B1B2B3, 64'hB0B1_B2B3_A0A1_A2A3, 8};
        tbl[2] = '{11'h123, 0, 32'h0, 32'h0, 64'h0, 0};
        tbl[3] = '{11'h400, 1, 32'hDEADBEEF, 32'h0, 64'h0000_0000_DEAD_BEEF, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", ren, 0);
        chk("rst_valid", valid, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_data", data, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            t = tbl[i];
            mem[t.base] = t.w0;
            if (t.cnt > 1) mem[t.base + 1'b1] = t.w1;
            run(t.base, t.cnt, 0, 0);
`ifdef X_SCOPE_DUMP_CSUM_EN
            chk("vec_len", got_b.size(), t.n + 1);
`else
            chk("vec_len", got_b.size(), t.n);
`endif
            x = '0;
            for (int j = 0; j < t.n && j < got_b.size(); j++) begin
                chk($sformatf("vec%0d_byte%0d", i, j), got_b[j], t.exp[8*j +: 8]);
                x ^= t.exp[8*j +: 8];
            end
`ifdef X_SCOPE_DUMP_CSUM_EN
            if (got_b.size() > t.n) chk($sformatf("vec%0d_csum", i), got_b[t.n], x);
`endif
        end

        mem[11'h010] = 32'h44332211;
        run(11'h010, 1, 2, 0);
        chk("stall_cycles", stall_n, 10);
        chk("stall_data_changes", stall_bad, 0);

        run(11'h200, 3, 0, 1);

        clear_mon();
        base = 11'h300;
        count = 12'd2;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        it = 0;
        while (got_b.size() < 5 && it < 100) begin
            @(posedge clk); #1;
            it++;
        end
        chk("pre_reset_bytes", got_b.size(), 5);
        rst = 1;
        #1;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ren", ren, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bytes_after_reset", got_b.size(), 5);
        rst = 0;
        @(posedge clk); #1;
        run(11'h5A5, 2, 0, 0);

        run(AW'($urandom), 1 << AW, 0, 0);

        for (int r = 0; r < 20; r++) run(AW'($urandom), $urandom_range(0, 6), 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
